// File: rtl/banco_registros_pkg.sv
// Shared definitions for the register bank and its debug dump engine.
package banco_registros_pkg;

  localparam int NUM_REG = 32;
  localparam int ANCHO   = 32;
  localparam int IDX_W   = 5;

  // Dump engine states
  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    CARGA  = 2'd1,
    ENVIO  = 2'd2,
    FIN    = 2'd3
  } estado_t;

endpackage

// File: rtl/volcado_registros.sv
// Debug dump engine: walks registers 0..NUM_REG-1, snapshots each one and
// streams it out byte by byte (little-endian) over a valid/ready handshake.
module volcado_registros #(
  parameter int NUM_REG = banco_registros_pkg::NUM_REG,
  parameter int ANCHO   = banco_registros_pkg::ANCHO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     volcar,
  input  logic [NUM_REG*ANCHO-1:0] registros,
  input  logic                     byte_listo,
  output logic                     ocupado,
  output logic [7:0]               byte_dato,
  output logic                     byte_valido,
  output logic                     fin_volcado
);
  import banco_registros_pkg::*;

  estado_t          estado;
  estado_t          estado_sig;
  logic [IDX_W-1:0] indice;
  logic [1:0]       contador;
  logic [ANCHO-1:0] instantanea;
  logic [ANCHO-1:0] vista [NUM_REG];
  logic             transferencia;
  logic             ultimo_byte;
  logic             ultimo_reg;

  // Unpack the flat bus so the selected register is a plain array read
  for (genvar g = 0; g < NUM_REG; g++) begin : g_vista
    assign vista[g] = registros[g*ANCHO +: ANCHO];
  end

  assign transferencia = (estado == ENVIO) && byte_listo;
  assign ultimo_byte   = (contador == 2'd3);
  assign ultimo_reg    = (indice == IDX_W'(NUM_REG - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state and handshake outputs; byte_dato only driven while offering a byte
  always_comb begin
    estado_sig  = estado;
    ocupado     = 1'b1;
    byte_valido = 1'b0;
    fin_volcado = 1'b0;
    byte_dato   = 8'h00;
    case (estado)
      REPOSO: begin
        ocupado = 1'b0;
        if (volcar) estado_sig = CARGA;
      end
      CARGA: estado_sig = ENVIO;
      ENVIO: begin
        byte_valido = 1'b1;
        byte_dato   = 8'(instantanea >> {contador, 3'b000});
        if (transferencia && ultimo_byte) estado_sig = ultimo_reg ? FIN : CARGA;
      end
      FIN: begin
        fin_volcado = 1'b1;
        estado_sig  = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Index, byte counter and snapshot; snapshot is frozen for the whole ENVIO
  // phase so byte_dato cannot move while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      indice      <= '0;
      contador    <= '0;
      instantanea <= '0;
    end else begin
      case (estado)
        REPOSO: if (volcar) indice <= '0;
        CARGA: begin
          instantanea <= vista[indice];
          contador    <= '0;
        end
        ENVIO: begin
          if (transferencia) begin
            if (!ultimo_byte)     contador <= contador + 2'd1;
            else if (!ultimo_reg) indice   <= indice + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/banco_registros.sv
// General-purpose register bank: one write port, all registers exposed on a
// flat bus, register 0 hardwired to zero, plus a byte-serial debug dump.
module banco_registros #(
  parameter int NUM_REG = banco_registros_pkg::NUM_REG,
  parameter int ANCHO   = banco_registros_pkg::ANCHO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     escribir,
  input  logic [4:0]               dir_escritura,
  input  logic [ANCHO-1:0]         dato_escritura,
  output logic [NUM_REG*ANCHO-1:0] registros,
  input  logic                     volcar,
  output logic                     ocupado,
  output logic [7:0]               byte_dato,
  output logic                     byte_valido,
  input  logic                     byte_listo,
  output logic                     fin_volcado
);
  import banco_registros_pkg::*;

  // Register 0 has no storage at all; it is a constant zero
  logic [ANCHO-1:0] mem [1:NUM_REG-1];

  // Write port; index 0 matches no storage element so those writes vanish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REG; i++) mem[i] <= '0;
    end else if (escribir) begin
      for (int i = 1; i < NUM_REG; i++) begin
        if (dir_escritura == IDX_W'(i)) mem[i] <= dato_escritura;
      end
    end
  end

  // Flat output straight from the flops, no bypass from the write inputs
  assign registros[ANCHO-1:0] = '0;
  for (genvar g = 1; g < NUM_REG; g++) begin : g_salida
    assign registros[g*ANCHO +: ANCHO] = mem[g];
  end

  volcado_registros #(
    .NUM_REG (NUM_REG),
    .ANCHO   (ANCHO)
  ) u_volcado (
    .clk         (clk),
    .rst_n       (rst_n),
    .volcar      (volcar),
    .registros   (registros),
    .byte_listo  (byte_listo),
    .ocupado     (ocupado),
    .byte_dato   (byte_dato),
    .byte_valido (byte_valido),
    .fin_volcado (fin_volcado)
  );

endmodule
